// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - round-robin arbiter sharing one single-port RAM between two Avalon-MM requesters
// Optional per-port stall counters: define MEM_ARB_STALL_CNT_EN.
module onchip_mem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,
`ifdef MEM_ARB_STALL_CNT_EN
    input  logic              stall_cnt_clr,
    output logic [31:0]       m0_stall_cnt,
    output logic [31:0]       m1_stall_cnt,
`endif
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int LAST = READ_LATENCY - 1;

    logic                    req0, req1, allow;
    logic                    gnt0, gnt1, gnt_rd;
    logic                    last_gnt;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [READ_LATENCY-1:0] pipe_own;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign allow = reset_n & ~freeze;

    // Under contention the port that did not win last time goes next.
    assign gnt0 = allow & req0 & (~req1 | last_gnt);
    assign gnt1 = allow & req1 & (~req0 | ~last_gnt);

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    // A simultaneous read+write on one port is treated as a write only.
    assign gnt_rd = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
    assign mem_address    = gnt1 ? m1_address   : m0_address;
    assign mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
    assign mem_byteenable = gnt_rd ? {BE_W{1'b1}} : (gnt1 ? m1_byteenable : m0_byteenable);
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_gnt <= 1'b0;
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            if (gnt0 | gnt1)
                last_gnt <= gnt1;
            pipe_vld[0] <= gnt_rd;
            pipe_own[0] <= gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    assign m0_readdatavalid = reset_n & pipe_vld[LAST] & ~pipe_own[LAST];
    assign m1_readdatavalid = reset_n & pipe_vld[LAST] &  pipe_own[LAST];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

`ifdef MEM_ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n || stall_cnt_clr) begin
            m0_stall_cnt <= '0;
            m1_stall_cnt <= '0;
        end else begin
            if (m0_waitrequest && m0_stall_cnt != 32'hFFFF_FFFF)
                m0_stall_cnt <= m0_stall_cnt + 32'd1;
            if (m1_waitrequest && m1_stall_cnt != 32'hFFFF_FFFF)
                m1_stall_cnt <= m1_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - directed scoreboard bench for onchip_mem_arbiter with a RAM model
module tb_onchip_mem_arbiter;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset_n, freeze;
    logic [13:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        mem_chipselect, mem_write, mem_clken;
`ifdef MEM_ARB_STALL_CNT_EN
    logic        stall_cnt_clr;
    logic [31:0] m0_stall_cnt, m1_stall_cnt;
`endif

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .BE_W(4), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset_n(reset_n), .freeze(freeze),
`ifdef MEM_ARB_STALL_CNT_EN
        .stall_cnt_clr(stall_cnt_clr), .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt),
`endif
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // RAM model: writes commit at the edge, reads return RL cycles after the command.
    logic [31:0] ram [0:16383];
    logic [31:0] rd_d1, rd_d2;
    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        if (mem_chipselect && !mem_write)
            rd_d1 <= ram[mem_address];
        rd_d2 <= rd_d1;
    end
    assign mem_readdata = (RL == 1) ? rd_d1 : rd_d2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        sb.push_back('{port: port, data: data, due: cyc + RL});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    always @(negedge clk) begin
        if (m0_readdatavalid || m1_readdatavalid) begin
            if (sb.size() == 0) begin
                chk("rv_unexpected", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rv_port", {30'd0, m1_readdatavalid, m0_readdatavalid}, mon_e.port ? 32'd2 : 32'd1);
                chk("rdata", mon_e.port ? m1_readdata : m0_readdata, mon_e.data);
                chk("rv_cycle", cyc, mon_e.due);
            end
        end
    end

    initial begin
        reset_n = 0; freeze = 0;
        m0_address = 0; m1_address = 0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = 0; m1_writedata = 0;
`ifdef MEM_ARB_STALL_CNT_EN
        stall_cnt_clr = 0;
`endif
        idle();
        ram[14'h0001] = 32'hA1A1_A1A1;
        ram[14'h0002] = 32'hB2B2_B2B2;
        ram[14'h0020] = 32'h1122_3344;

        // reset behaviour
        tick();
        m0_read = 1; m1_write = 1;
        #1;
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_wait1", m1_waitrequest, 1);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_we", mem_write, 0);
        chk("rst_rv", {m1_readdatavalid, m0_readdatavalid}, 0);
        tick();
        idle();
        reset_n = 1;

        // continuous contention: m1 first, then strict alternation
        for (int i = 0; i < 6; i++) begin
            m0_read = 1; m0_address = 14'h0001;
            m1_read = 1; m1_address = 14'h0002;
            #1;
            chk("cont_wait0", m0_waitrequest, (i % 2 == 0) ? 1 : 0);
            chk("cont_wait1", m1_waitrequest, (i % 2 == 0) ? 0 : 1);
            chk("cont_addr", mem_address, (i % 2 == 0) ? 32'h2 : 32'h1);
            if (i % 2 == 0) push(1, 32'hB2B2_B2B2);
            else            push(0, 32'hA1A1_A1A1);
            tick();
        end
        idle();
        repeat (4) tick();

        // m0 write then read back
        m0_write = 1; m0_address = 14'h0010; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF;
        #1;
        chk("wr_wait0", m0_waitrequest, 0);
        chk("wr_cs", mem_chipselect, 1);
        chk("wr_we", mem_write, 1);
        tick();
        m0_write = 0; m0_read = 1; m0_byteenable = 4'h0;
        #1;
        chk("rd_wait0", m0_waitrequest, 0);
        chk("rd_be", mem_byteenable, 4'hF);
        chk("rd_we", mem_write, 0);
        push(0, 32'hDEAD_BEEF);
        tick();
        idle();
        repeat (4) tick();

        // m1 byte-lane write
        m1_write = 1; m1_address = 14'h0020; m1_writedata = 32'h0000_AB00; m1_byteenable = 4'h2;
        #1;
        chk("bw_wait1", m1_waitrequest, 0);
        chk("bw_be", mem_byteenable, 4'h2);
        tick();
        m1_write = 0; m1_read = 1;
        push(1, 32'h1122_AB44);
        tick();
        idle();
        repeat (4) tick();

        // write then read of the same word on consecutive cycles
        m0_write = 1; m0_address = 14'h0030; m0_writedata = 32'hCAFE_F00D; m0_byteenable = 4'hF;
        tick();
        idle();
        m1_read = 1; m1_address = 14'h0030;
        #1;
        chk("rdw_wait1", m1_waitrequest, 0);
        push(1, 32'hCAFE_F00D);
        tick();
        idle();
        repeat (4) tick();

        // freeze with a read in flight
        m0_read = 1; m0_address = 14'h0010;
        push(0, 32'hDEAD_BEEF);
        tick();
        freeze = 1; m0_address = 14'h0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fz_wait0", m0_waitrequest, 1);
            chk("fz_cs", mem_chipselect, 0);
            tick();
        end
        freeze = 0;
        #1;
        chk("fz_release", m0_waitrequest, 0);
        push(0, 32'hA1A1_A1A1);
        tick();
        idle();
        repeat (4) tick();

        // reset while an m0 read is in flight: return is dropped
        m0_read = 1; m0_address = 14'h0010;
        tick();
        idle();
        reset_n = 0;
        #1;
        chk("rr_cs", mem_chipselect, 0);
        tick();
        chk("rr_rv", {m1_readdatavalid, m0_readdatavalid}, 0);
        reset_n = 1;
        m0_read = 1; m0_address = 14'h0001;
        m1_read = 1; m1_address = 14'h0002;
        #1;
        chk("rr_wait0", m0_waitrequest, 1);
        chk("rr_wait1", m1_waitrequest, 0);
        push(1, 32'hB2B2_B2B2);
        tick();
        idle();
        repeat (5) tick();

`ifdef MEM_ARB_STALL_CNT_EN
        reset_n = 0;
        tick();
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            m0_read = 1; m0_address = 14'h0001;
            m1_read = 1; m1_address = 14'h0002;
            if (i % 2 == 0) push(1, 32'hB2B2_B2B2);
            else            push(0, 32'hA1A1_A1A1);
            tick();
        end
        idle();
        #1;
        chk("stall_cnt0", m0_stall_cnt, 2);
        chk("stall_cnt1", m1_stall_cnt, 2);
        stall_cnt_clr = 1;
        tick();
        stall_cnt_clr = 0;
        chk("stall_clr0", m0_stall_cnt, 0);
        chk("stall_clr1", m1_stall_cnt, 0);
        repeat (4) tick();
`endif

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
